// File: rtl/rps_pkg.sv
// Shared encodings, FSM states and helpers for the rock-paper-scissors match controller.
package rps_pkg;

    // One-hot move encodings
    localparam logic [2:0] ROCK     = 3'b100;
    localparam logic [2:0] PAPER    = 3'b010;
    localparam logic [2:0] SCISSORS = 3'b001;

    // Round result / match winner codes
    localparam logic [1:0] RES_TIE = 2'b00;
    localparam logic [1:0] RES_A   = 2'b10;
    localparam logic [1:0] RES_B   = 2'b01;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_JUDGE,
        ST_DONE
    } state_t;

    // True only for one of the three legal move encodings
    function automatic logic is_onehot3(input logic [2:0] move);
        return (move == ROCK) || (move == PAPER) || (move == SCISSORS);
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: decides which of two legal moves wins.
module rps_judge
    import rps_pkg::*;
(
    input  logic [2:0] move_a,
    input  logic [2:0] move_b,
    output logic [1:0] result
);

    logic a_beats_b;
    logic b_beats_a;

    // Each legal move beats exactly one other move; anything else (including equal or illegal moves) is a tie
    always_comb begin
        a_beats_b = ((move_a == ROCK)     && (move_b == SCISSORS)) ||
                    ((move_a == PAPER)    && (move_b == ROCK))     ||
                    ((move_a == SCISSORS) && (move_b == PAPER));
        b_beats_a = ((move_b == ROCK)     && (move_a == SCISSORS)) ||
                    ((move_b == PAPER)    && (move_a == ROCK))     ||
                    ((move_b == SCISSORS) && (move_a == PAPER));
        result = RES_TIE;
        if (a_beats_b) begin
            result = RES_A;
        end else if (b_beats_a) begin
            result = RES_B;
        end
    end

endmodule

// File: rtl/rps_match_ctrl.sv
// Match controller: collects one move per player per round, judges it, tallies wins
// and declares a match winner (first to WINS_TO_MATCH) or a draw after MAX_ROUNDS.
module rps_match_ctrl
    import rps_pkg::*;
#(
    parameter int WINS_TO_MATCH = 2,
    parameter int MAX_ROUNDS    = 15,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       move_a,
    input  logic             move_a_valid,
    output logic             move_a_ready,
    input  logic [2:0]       move_b,
    input  logic             move_b_valid,
    output logic             move_b_ready,
    output logic [1:0]       round_result,
    output logic             round_valid,
    output logic             move_err,
    output logic [CNT_W-1:0] wins_a,
    output logic [CNT_W-1:0] wins_b,
    output logic [CNT_W-1:0] round_cnt,
    output logic             match_done,
    output logic [1:0]       match_winner
);

    localparam logic [CNT_W-1:0] WINS_LIM   = CNT_W'(WINS_TO_MATCH);
    localparam logic [CNT_W-1:0] ROUNDS_LIM = CNT_W'(MAX_ROUNDS);

    state_t           state, state_next;
    logic             cap_a, cap_a_next;
    logic             cap_b, cap_b_next;
    logic [2:0]       mv_a, mv_a_next;
    logic [2:0]       mv_b, mv_b_next;
    logic [CNT_W-1:0] wins_a_next, wins_b_next, round_cnt_next;
    logic [CNT_W-1:0] wins_a_inc, wins_b_inc;
    logic [1:0]       round_result_next;
    logic             round_valid_next;
    logic             move_err_next;
    logic             match_done_next;
    logic [1:0]       match_winner_next;
    logic [1:0]       judge_res;
    logic             a_fire, b_fire;

    rps_judge u_judge (
        .move_a (mv_a),
        .move_b (mv_b),
        .result (judge_res)
    );

    // A player can hand over a move only while collecting and not yet captured this round
    assign move_a_ready = (state == ST_COLLECT) && !cap_a;
    assign move_b_ready = (state == ST_COLLECT) && !cap_b;
    assign a_fire       = move_a_valid && move_a_ready;
    assign b_fire       = move_b_valid && move_b_ready;

    // Post-increment tallies, used both for the update and the termination test
    assign wins_a_inc = wins_a + {{(CNT_W-1){1'b0}}, (judge_res == RES_A)};
    assign wins_b_inc = wins_b + {{(CNT_W-1){1'b0}}, (judge_res == RES_B)};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-value logic for the whole controller
    always_comb begin
        state_next        = state;
        cap_a_next        = cap_a;
        cap_b_next        = cap_b;
        mv_a_next         = mv_a;
        mv_b_next         = mv_b;
        wins_a_next       = wins_a;
        wins_b_next       = wins_b;
        round_cnt_next    = round_cnt;
        round_result_next = round_result;
        round_valid_next  = 1'b0;
        move_err_next     = 1'b0;
        match_done_next   = match_done;
        match_winner_next = match_winner;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next        = ST_COLLECT;
                    cap_a_next        = 1'b0;
                    cap_b_next        = 1'b0;
                    wins_a_next       = '0;
                    wins_b_next       = '0;
                    round_cnt_next    = '0;
                    round_result_next = RES_TIE;
                    match_done_next   = 1'b0;
                    match_winner_next = RES_TIE;
                end
            end
            ST_COLLECT: begin
                if (a_fire) begin
                    cap_a_next = 1'b1;
                    mv_a_next  = move_a;
                end
                if (b_fire) begin
                    cap_b_next = 1'b1;
                    mv_b_next  = move_b;
                end
                if (cap_a_next && cap_b_next) begin
                    state_next = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                cap_a_next = 1'b0;
                cap_b_next = 1'b0;
                if (!is_onehot3(mv_a) || !is_onehot3(mv_b)) begin
                    move_err_next = 1'b1;
                    state_next    = ST_COLLECT;
                end else begin
                    round_valid_next  = 1'b1;
                    round_result_next = judge_res;
                    wins_a_next       = wins_a_inc;
                    wins_b_next       = wins_b_inc;
                    round_cnt_next    = round_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (wins_a_inc == WINS_LIM) begin
                        state_next        = ST_DONE;
                        match_done_next   = 1'b1;
                        match_winner_next = RES_A;
                    end else if (wins_b_inc == WINS_LIM) begin
                        state_next        = ST_DONE;
                        match_done_next   = 1'b1;
                        match_winner_next = RES_B;
                    end else if (round_cnt_next == ROUNDS_LIM) begin
                        state_next        = ST_DONE;
                        match_done_next   = 1'b1;
                        match_winner_next = RES_TIE;
                    end else begin
                        state_next = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Captured moves, tallies and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_a        <= 1'b0;
            cap_b        <= 1'b0;
            mv_a         <= '0;
            mv_b         <= '0;
            wins_a       <= '0;
            wins_b       <= '0;
            round_cnt    <= '0;
            round_result <= RES_TIE;
            round_valid  <= 1'b0;
            move_err     <= 1'b0;
            match_done   <= 1'b0;
            match_winner <= RES_TIE;
        end else begin
            cap_a        <= cap_a_next;
            cap_b        <= cap_b_next;
            mv_a         <= mv_a_next;
            mv_b         <= mv_b_next;
            wins_a       <= wins_a_next;
            wins_b       <= wins_b_next;
            round_cnt    <= round_cnt_next;
            round_result <= round_result_next;
            round_valid  <= round_valid_next;
            move_err     <= move_err_next;
            match_done   <= match_done_next;
            match_winner <= match_winner_next;
        end
    end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Scoreboard bench for rps_match_ctrl: each driven round pushes its expected outcome,
// a negedge monitor pops and compares whenever the controller reports a round.
module tb_rps_match_ctrl;

    localparam int WINS  = 2;
    localparam int MAXR  = 15;
    localparam int CW    = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    move_a;
    logic          move_a_valid;
    logic          move_a_ready;
    logic [2:0]    move_b;
    logic          move_b_valid;
    logic          move_b_ready;
    logic [1:0]    round_result;
    logic          round_valid;
    logic          move_err;
    logic [CW-1:0] wins_a;
    logic [CW-1:0] wins_b;
    logic [CW-1:0] round_cnt;
    logic          match_done;
    logic [1:0]    match_winner;

    typedef struct {
        logic          err;
        logic [1:0]    res;
        logic [CW-1:0] wa;
        logic [CW-1:0] wb;
        logic [CW-1:0] rc;
        logic          done;
        logic [1:0]    win;
    } exp_t;

    exp_t          sb_q[$];
    int            error_count = 0;
    int            check_count = 0;

    logic [1:0]    m_res;
    logic [CW-1:0] m_wa, m_wb, m_rc;
    logic          m_done;
    logic [1:0]    m_win;

    rps_match_ctrl #(
        .WINS_TO_MATCH (WINS),
        .MAX_ROUNDS    (MAXR),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .move_a       (move_a),
        .move_a_valid (move_a_valid),
        .move_a_ready (move_a_ready),
        .move_b       (move_b),
        .move_b_valid (move_b_valid),
        .move_b_ready (move_b_ready),
        .round_result (round_result),
        .round_valid  (round_valid),
        .move_err     (move_err),
        .wins_a       (wins_a),
        .wins_b       (wins_b),
        .round_cnt    (round_cnt),
        .match_done   (match_done),
        .match_winner (match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_count++;
        if (got !== want) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Model move index: rock 0, paper 1, scissors 2
    function automatic int moveIdx(input logic [2:0] m);
        if (m == 3'b100) return 0;
        if (m == 3'b010) return 1;
        return 2;
    endfunction

    // Round outcome from cyclic distance: 1 means A's move is one step ahead and wins
    function automatic logic [1:0] judgeModel(input logic [2:0] a, input logic [2:0] b);
        int d;
        d = (moveIdx(a) - moveIdx(b) + 3) % 3;
        if (d == 0) return 2'b00;
        if (d == 1) return 2'b10;
        return 2'b01;
    endfunction

    task automatic modelClear();
        m_res  = 2'b00;
        m_wa   = '0;
        m_wb   = '0;
        m_rc   = '0;
        m_done = 1'b0;
        m_win  = 2'b00;
    endtask

    // Advance the model for one round and queue what the DUT should report
    task automatic pushExpected(input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        if ($countones(a) != 1 || $countones(b) != 1) begin
            e.err = 1'b1;
        end else begin
            e.err = 1'b0;
            m_res = judgeModel(a, b);
            if (m_res == 2'b10) m_wa = m_wa + 1'b1;
            if (m_res == 2'b01) m_wb = m_wb + 1'b1;
            m_rc = m_rc + 1'b1;
            if (int'(m_wa) == WINS) begin
                m_done = 1'b1; m_win = 2'b10;
            end else if (int'(m_wb) == WINS) begin
                m_done = 1'b1; m_win = 2'b01;
            end else if (int'(m_rc) == MAXR) begin
                m_done = 1'b1; m_win = 2'b00;
            end
        end
        e.res  = m_res;
        e.wa   = m_wa;
        e.wb   = m_wb;
        e.rc   = m_rc;
        e.done = m_done;
        e.win  = m_win;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every reported round against the oldest queued expectation
    always @(negedge clk) begin
        if (round_valid || move_err) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_event", 32'({round_valid, move_err}), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("move_err",     32'(move_err),     32'(e.err));
                checkOutput("round_valid",  32'(round_valid),  32'(!e.err));
                checkOutput("round_result", 32'(round_result), 32'(e.res));
                checkOutput("wins_a",       32'(wins_a),       32'(e.wa));
                checkOutput("wins_b",       32'(wins_b),       32'(e.wb));
                checkOutput("round_cnt",    32'(round_cnt),    32'(e.rc));
                checkOutput("match_done",   32'(match_done),   32'(e.done));
                checkOutput("match_winner", 32'(match_winner), 32'(e.win));
            end
        end
    end

    // Drive one round; B is presented b_lag cycles after A. Waits for the report to drain.
    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input int b_lag);
        logic a_done, b_done, a_take, b_take;
        int   cycles;
        pushExpected(a, b);
        move_a       = a;
        move_b       = b;
        move_a_valid = 1'b1;
        move_b_valid = (b_lag == 0);
        a_done = 1'b0;
        b_done = 1'b0;
        cycles = 0;
        while (!(a_done && b_done) && cycles < 50) begin
            @(negedge clk);
            a_take = move_a_valid && move_a_ready;
            b_take = move_b_valid && move_b_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (a_take) begin a_done = 1'b1; move_a_valid = 1'b0; end
            if (b_take) begin b_done = 1'b1; move_b_valid = 1'b0; end
            if (!b_done && !move_b_valid && cycles >= b_lag) move_b_valid = 1'b1;
        end
        if (!(a_done && b_done)) checkOutput("handshake_timeout", 32'({a_done, b_done}), 32'd3);
        move_a_valid = 1'b0;
        move_b_valid = 1'b0;
        cycles = 0;
        while (sb_q.size() != 0 && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("result_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic applyReset();
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        modelClear();
        checkOutput("rst_round_result", 32'(round_result), 32'd0);
        checkOutput("rst_round_valid",  32'(round_valid),  32'd0);
        checkOutput("rst_move_err",     32'(move_err),     32'd0);
        checkOutput("rst_wins_a",       32'(wins_a),       32'd0);
        checkOutput("rst_wins_b",       32'(wins_b),       32'd0);
        checkOutput("rst_round_cnt",    32'(round_cnt),    32'd0);
        checkOutput("rst_match_done",   32'(match_done),   32'd0);
        checkOutput("rst_match_winner", 32'(match_winner), 32'd0);
        checkOutput("rst_ready",        32'({move_a_ready, move_b_ready}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Post-round status checks against the model
    task automatic checkStatus(input string tag);
        checkOutput({tag, "_wins_a"},    32'(wins_a),       32'(m_wa));
        checkOutput({tag, "_wins_b"},    32'(wins_b),       32'(m_wb));
        checkOutput({tag, "_round_cnt"}, 32'(round_cnt),    32'(m_rc));
        checkOutput({tag, "_done"},      32'(match_done),   32'(m_done));
        checkOutput({tag, "_winner"},    32'(match_winner), 32'(m_win));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        move_a       = 3'b000;
        move_b       = 3'b000;
        move_a_valid = 1'b0;
        move_b_valid = 1'b0;
        modelClear();
        @(posedge clk);
        #1;
        applyReset();

        // Match 1: A rock beats B scissors twice
        $display("[TB] match 1: A wins best-of-3");
        pulseStart();
        checkOutput("start_ready", 32'({move_a_ready, move_b_ready}), 32'd3);
        applyStimulus(3'b100, 3'b001, 0);
        applyStimulus(3'b100, 3'b001, 0);
        checkStatus("m1");
        checkOutput("m1_ready_done", 32'({move_a_ready, move_b_ready}), 32'd0);

        // Start from DONE clears everything
        pulseStart();
        modelClear();
        checkStatus("restart");
        checkOutput("restart_result", 32'(round_result), 32'd0);
        checkOutput("restart_ready", 32'({move_a_ready, move_b_ready}), 32'd3);

        // Match 2: simultaneous capture, then B arrives 3 cycles after A
        $display("[TB] match 2: B wins with staggered moves");
        applyStimulus(3'b010, 3'b001, 0);
        applyStimulus(3'b010, 3'b001, 3);
        checkStatus("m2");

        // Match 3: start ignored in COLLECT, illegal move replayed
        $display("[TB] match 3: ignored start and move error");
        pulseStart();
        modelClear();
        applyStimulus(3'b100, 3'b010, 0);
        pulseStart();
        pulseStart();
        checkStatus("ign_start");
        applyStimulus(3'b110, 3'b010, 0);
        checkStatus("replay");
        checkOutput("replay_ready", 32'({move_a_ready, move_b_ready}), 32'd3);
        applyStimulus(3'b001, 3'b010, 1);
        checkStatus("after_replay");

        // Reset with A captured; the stale capture must not survive
        $display("[TB] reset mid-collect");
        move_a       = 3'b100;
        move_a_valid = 1'b1;
        @(posedge clk);
        #1;
        move_a_valid = 1'b0;
        checkOutput("a_captured_ready", 32'(move_a_ready), 32'd0);
        applyReset();
        pulseStart();
        move_b       = 3'b001;
        move_b_valid = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            move_b_valid = 1'b0;
        end
        checkOutput("fresh_a_needed", 32'({move_a_ready, move_b_ready}), 32'd2);
        checkOutput("no_stale_round", 32'(round_cnt), 32'd0);
        pushExpected(3'b100, 3'b001);
        move_a_valid = 1'b1;
        @(posedge clk);
        #1;
        move_a_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("fresh_round_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        checkStatus("fresh");

        // Match 4: fifteen ties (one illegal replay in between) end in a draw
        $display("[TB] match 4: draw by ties");
        applyReset();
        pulseStart();
        for (int i = 0; i < MAXR; i++) begin
            logic [2:0] m;
            m = (i % 3 == 0) ? 3'b100 : ((i % 3 == 1) ? 3'b010 : 3'b001);
            if (i == 7) applyStimulus(m, 3'b000, 0);
            applyStimulus(m, m, 0);
            if (i == 7) checkStatus("mid_ties");
        end
        checkStatus("draw");
        checkOutput("draw_ready", 32'({move_a_ready, move_b_ready}), 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
